sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//  Parametrised single-clock FIFO; generalised successor to the fixed 64-bit buffer.
//  Configurable data width and depth, almost-full/almost-empty thresholds, synchronous flush.
//  Sticky overflow/underflow error flags and optional first-word-fall-through (FWFT) read mode.
//  Sits between pipeline producers and consumers (e.g. instruction/data queues).
// PARAMETERS
//  DATA_W     64  data word width in bits
//  ADDR_W     4   pointer width; DEPTH = 2**ADDR_W entries
//  AF_THRESH  12  almost_full asserted when count >= AF_THRESH (1..DEPTH)
//  AE_THRESH  2   almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
//  FWFT       0   0 = registered read (1-cycle latency); 1 = head word visible on rd_data
// PORTS
//  clk           in   1         clock, all state updates on rising edge
//  rst           in   1         reset, asynchronous, active-high
//  flush         in   1         synchronous clear of contents
//  wr_en         in   1         write request
//  wr_data       in   DATA_W    write data
//  rd_en         in   1         read request (acknowledge of head word in FWFT mode)
//  rd_data       out  DATA_W    read data
//  rd_valid      out  1         rd_data valid
//  count         out  ADDR_W+1  number of stored words, 0..DEPTH
//  empty         out  1         count == 0
//  full          out  1         count == DEPTH
//  almost_empty  out  1         count <= AE_THRESH
//  almost_full   out  1         count >= AF_THRESH
//  overflow      out  1         sticky: write attempted while full and not accepted
//  underflow     out  1         sticky: read attempted while empty
//  clr_err       in   1         synchronous clear of overflow/underflow
// BEHAVIOUR
//  Reset (async): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, almost_empty=1.
//   almost_full=0, rd_data=0, rd_valid=0, overflow=0, underflow=0. Memory not cleared.
//  rd_acc = rd_en & ~empty.
//  wr_acc = wr_en & (~full | rd_acc). Full + simultaneous read: both accepted, count unchanged.
//  Empty + simultaneous rd/wr: write accepted, read rejected (underflow set), count -> 1.
//  Pointers ADDR_W bits, increment on acceptance, wrap DEPTH-1 -> 0 naturally.
//  count: +1 on wr_acc only; -1 on rd_acc only; unchanged on both or neither.
//  All flags registered, computed from next-count, so they change on the same edge as count.
//  Write-to-read visibility: word written at edge N is readable from edge N+1 (empty=0 after N).
//  FWFT=0: rd_acc at edge N loads mem[rd_ptr] into rd_data at N; rd_valid=1 for that one cycle.
//   Otherwise rd_valid=0 and rd_data holds its last value.
//  FWFT=1: rd_data = mem[rd_ptr] combinationally, rd_valid = ~empty; rd_acc pops the head.
//  flush: highest priority after rst; pointers, count -> 0 and flags as reset.
//   rd_valid -> 0; wr_en/rd_en that cycle ignored, no error flags set.
//   overflow/underflow and stored rd_data (FWFT=0) are NOT cleared by flush.
//  overflow set when wr_en & ~wr_acc; underflow set when rd_en & empty (not during flush).
//   Both held until clr_err; set wins over clr_err in the same cycle.
//  rst asserted mid-transfer discards all contents immediately; no partial write completes.
// TESTING
//  1. Reset, write 0x11..0x1F (15 words, DEPTH=16) -> count=15, almost_full=1, full=0.
//  2. Write 0x20 -> full=1; extra write 0x21 -> overflow=1, count=16, 0x21 never read back.
//  3. At full, rd_en+wr_en 0x30 together -> count stays 16, 0x11 read out, 0x30 read last.
//  4. Drain to empty, then rd_en -> underflow=1, rd_valid=0; clr_err -> underflow=0.
//  5. FWFT=1: write 0xAB on empty -> next cycle rd_valid=1, rd_data=0xAB; rd_en -> empty=1.
//  6. 20 writes / 20 reads interleaved (pointer wrap) then flush with wr_en=1.
//   -> FIFO order preserved across wrap; after flush count=0, empty=1, overflow unchanged.

Source files
------------

// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle for sync_fifo_param.
// master drives requests (producer/consumer side), slave is the FIFO.
interface sync_fifo_param_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 4
);
    logic              flush;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic              clr_err;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [ADDR_W:0]   count;
    logic              empty;
    logic              full;
    logic              almost_empty;
    logic              almost_full;
    logic              overflow;
    logic              underflow;

    modport master (
        output flush, wr_en, wr_data, rd_en, clr_err,
        input  rd_data, rd_valid, count, empty, full,
               almost_empty, almost_full, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, wr_data, rd_en, clr_err,
        output rd_data, rd_valid, count, empty, full,
               almost_empty, almost_full, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered status flags, sticky
// overflow/underflow, synchronous flush and optional first-word-fall-through.
module sync_fifo_param #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 4,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input logic              clk,
    input logic              rst,
    sync_fifo_param_if.slave bus
);
    localparam int CNT_W = ADDR_W + 1;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              almost_empty_q, almost_empty_d;
    logic              almost_full_q, almost_full_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic rd_acc, wr_acc, rd_fire, wr_fire;

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        rd_acc  = bus.rd_en & ~empty_q;
        wr_acc  = bus.wr_en & (~full_q | rd_acc);
        rd_fire = rd_acc & ~bus.flush;
        wr_fire = wr_acc & ~bus.flush;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_fire) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (rd_fire) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            case ({wr_fire, rd_fire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        // Flags come from the next count so they move on the same edge as count.
        empty_d        = (count_d == '0);
        full_d         = (count_d == DEPTH_C);
        almost_empty_d = (count_d <= AE_C);
        almost_full_d  = (count_d >= AF_C);

        // Setting takes precedence over clr_err; flush never sets an error.
        overflow_d  = (bus.wr_en & ~wr_acc & ~bus.flush) | (overflow_q & ~bus.clr_err);
        underflow_d = (bus.rd_en & empty_q & ~bus.flush) | (underflow_q & ~bus.clr_err);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            empty_q        <= 1'b1;
            full_q         <= 1'b0;
            almost_empty_q <= 1'b1;
            almost_full_q  <= 1'b0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            empty_q        <= empty_d;
            full_q         <= full_d;
            almost_empty_q <= almost_empty_d;
            almost_full_q  <= almost_full_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    // NOTE: the storage array has no reset; reset discards contents via pointers and count.
    always_ff @(posedge clk) begin
        if (wr_fire) mem_q[wr_ptr_q] <= bus.wr_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.rd_data  = mem_q[rd_ptr_q];
            assign bus.rd_valid = ~empty_q;
        end else begin : g_reg
            logic [DATA_W-1:0] rd_data_q, rd_data_d;
            logic              rd_valid_q, rd_valid_d;

            always_comb begin
                rd_valid_d = rd_fire;
                rd_data_d  = rd_fire ? mem_q[rd_ptr_q] : rd_data_q;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_data_q  <= rd_data_d;
                    rd_valid_q <= rd_valid_d;
                end
            end

            assign bus.rd_data  = rd_data_q;
            assign bus.rd_valid = rd_valid_q;
        end
    endgenerate

    assign bus.count        = count_q;
    assign bus.empty        = empty_q;
    assign bus.full         = full_q;
    assign bus.almost_empty = almost_empty_q;
    assign bus.almost_full  = almost_full_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: registered-read instance (a) and FWFT instance (b).
// Inputs change 1 ns after the rising edge, outputs are sampled at the same point.
module tb_sync_fifo_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_W(64), .ADDR_W(4)) a ();
    sync_fifo_param_if #(.DATA_W(64), .ADDR_W(4)) b ();

    sync_fifo_param #(.DATA_W(64), .ADDR_W(4), .AF_THRESH(12), .AE_THRESH(2), .FWFT(0))
        dut_a (.clk(clk), .rst(rst), .bus(a.slave));
    sync_fifo_param #(.DATA_W(64), .ADDR_W(4), .AF_THRESH(12), .AE_THRESH(2), .FWFT(1))
        dut_b (.clk(clk), .rst(rst), .bus(b.slave));

    logic [63:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] e;
        a.flush = 0; a.wr_en = 0; a.wr_data = '0; a.rd_en = 0; a.clr_err = 0;
        b.flush = 0; b.wr_en = 0; b.wr_data = '0; b.rd_en = 0; b.clr_err = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 64'(a.count), 64'd0);
        check("rst_empty", 64'(a.empty), 64'd1);
        check("rst_full", 64'(a.full), 64'd0);
        check("rst_ae", 64'(a.almost_empty), 64'd1);
        check("rst_af", 64'(a.almost_full), 64'd0);
        check("rst_rd_data", a.rd_data, 64'd0);
        check("rst_rd_valid", 64'(a.rd_valid), 64'd0);
        check("rst_ovf", 64'(a.overflow), 64'd0);
        check("rst_udf", 64'(a.underflow), 64'd0);
        check("rst_b_rd_valid", 64'(b.rd_valid), 64'd0);
        rst = 0;

        // 1: fifteen writes 0x11..0x1F
        for (int i = 0; i < 15; i++) begin
            a.wr_en = 1; a.wr_data = 64'h11 + 64'(i);
            step();
            check("fill_count", 64'(a.count), 64'(i + 1));
            check("fill_ae", 64'(a.almost_empty), ((i + 1) <= 2) ? 64'd1 : 64'd0);
        end
        check("t1_af", 64'(a.almost_full), 64'd1);
        check("t1_full", 64'(a.full), 64'd0);

        // 2: reach full, then a rejected write
        a.wr_data = 64'h20;
        step();
        check("t2_full", 64'(a.full), 64'd1);
        check("t2_count", 64'(a.count), 64'd16);
        check("t2_ovf_pre", 64'(a.overflow), 64'd0);
        a.wr_data = 64'h21;
        step();
        check("t2_ovf", 64'(a.overflow), 64'd1);
        check("t2_count_hold", 64'(a.count), 64'd16);

        // 3: simultaneous read and write at full
        a.wr_data = 64'h30; a.rd_en = 1;
        step();
        check("t3_count", 64'(a.count), 64'd16);
        check("t3_full", 64'(a.full), 64'd1);
        check("t3_rd_valid", 64'(a.rd_valid), 64'd1);
        check("t3_rd_data", a.rd_data, 64'h11);

        // 4: drain; 0x30 must be last and 0x21 absent
        a.wr_en = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            e = (k < 15) ? 64'h12 + 64'(k) : 64'h30;
            check("drain_data", a.rd_data, e);
            check("drain_valid", 64'(a.rd_valid), 64'd1);
            check("drain_count", 64'(a.count), 64'(15 - k));
        end
        check("t4_empty", 64'(a.empty), 64'd1);
        step();
        check("t4_udf", 64'(a.underflow), 64'd1);
        check("t4_rd_valid", 64'(a.rd_valid), 64'd0);
        check("t4_rd_data_hold", a.rd_data, 64'h30);
        check("t4_count", 64'(a.count), 64'd0);
        a.rd_en = 0; a.clr_err = 1;
        step();
        check("t4_udf_clr", 64'(a.underflow), 64'd0);
        check("t4_ovf_clr", 64'(a.overflow), 64'd0);
        a.rd_en = 1;
        step();
        check("t4_set_wins", 64'(a.underflow), 64'd1);
        a.rd_en = 0; a.clr_err = 0;

        // 6: interleaved traffic wrapping the pointers
        for (int c = 0; c < 24; c++) begin
            a.wr_en = (c < 20); a.rd_en = (c >= 4); a.wr_data = 64'h40 + 64'(c);
            step();
            if (c >= 4) begin
                e = exp_q.pop_front();
                check("wrap_data", a.rd_data, e);
            end
            if (c < 20) exp_q.push_back(64'h40 + 64'(c));
            check("wrap_count", 64'(a.count), 64'(exp_q.size()));
        end
        a.rd_en = 0;
        for (int i = 0; i < 3; i++) begin
            a.wr_en = 1; a.wr_data = 64'h70 + 64'(i);
            step();
        end
        check("pre_flush_count", 64'(a.count), 64'd3);
        a.flush = 1; a.wr_en = 1; a.rd_en = 1; a.wr_data = 64'h7F;
        step();
        a.flush = 0; a.wr_en = 0; a.rd_en = 0;
        check("flush_count", 64'(a.count), 64'd0);
        check("flush_empty", 64'(a.empty), 64'd1);
        check("flush_ae", 64'(a.almost_empty), 64'd1);
        check("flush_rd_valid", 64'(a.rd_valid), 64'd0);
        check("flush_rd_data_hold", a.rd_data, 64'h53);
        check("flush_ovf", 64'(a.overflow), 64'd0);
        check("flush_udf_kept", 64'(a.underflow), 64'd1);
        a.wr_en = 1; a.wr_data = 64'h99;
        step();
        a.wr_en = 0; a.rd_en = 1;
        step();
        a.rd_en = 0;
        check("post_flush_data", a.rd_data, 64'h99);
        check("post_flush_count", 64'(a.count), 64'd0);

        // 5: FWFT instance
        b.wr_en = 1; b.wr_data = 64'hAB;
        step();
        b.wr_en = 0;
        check("fwft_valid", 64'(b.rd_valid), 64'd1);
        check("fwft_data", b.rd_data, 64'hAB);
        check("fwft_empty", 64'(b.empty), 64'd0);
        b.rd_en = 1;
        step();
        b.rd_en = 0;
        check("fwft_pop_empty", 64'(b.empty), 64'd1);
        check("fwft_pop_valid", 64'(b.rd_valid), 64'd0);

        // Asynchronous reset in the middle of traffic
        a.wr_en = 1; a.wr_data = 64'h55;
        step();
        check("pre_rst_count", 64'(a.count), 64'd1);
        #2 rst = 1;
        #1;
        check("async_rst_count", 64'(a.count), 64'd0);
        check("async_rst_empty", 64'(a.empty), 64'd1);
        check("async_rst_udf", 64'(a.underflow), 64'd0);
        step();
        rst = 0; a.wr_en = 0;
        step();
        check("post_rst_count", 64'(a.count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
